// File: rtl/msk_pkg.sv
// ---------------------------------------------------------------------------
// msk_pkg
// Shared definitions for the masked-ciphertext output path: the FSM state
// type, the share-index mapping used to pick share j of ciphertext bit o out
// of a flattened masked bus, and helpers that derive the output word count
// from the chosen word width.
// ---------------------------------------------------------------------------
package msk_pkg;

    // The ciphertext is always one 128-bit block.
    localparam int CT_BITS = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNMASK = 2'd1,
        SEND   = 2'd2
    } state_e;

    // Share j of bit o sits at flat index d*o + j.
    function automatic int idx(input int o, input int j, input int d);
        return d * o + j;
    endfunction

    // Number of output words needed to stream the whole ciphertext.
    function automatic int nwOf(input int w);
        return CT_BITS / w;
    endfunction

    // Only widths that tile the 128-bit block evenly are supported.
    function automatic bit wLegal(input int w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64) || (w == 128);
    endfunction

    // Word counter width; kept at least one bit so NW==1 still has a counter.
    function automatic int cntWidth(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/msk_share_xor.sv
// ---------------------------------------------------------------------------
// msk_share_xor
// Purely combinational recombination of one W-bit word from its d shares.
// The slice holds W*d bits laid out with share j of bit i at index d*i+j.
//
// Ports:
//   shares_i  W*d  share slice of one output word
//   word_o    W    XOR of all shares, bit by bit
// ---------------------------------------------------------------------------
module msk_share_xor
    import msk_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 32
) (
    input  logic [W*d-1:0] shares_i,
    output logic [W-1:0]   word_o
);

    // Fold the d shares of every bit together.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < d; j++) begin
                word_o[i] = word_o[i] ^ shares_i[idx(i, j, d)];
            end
        end
    end

endmodule

// File: rtl/msk_ct_unmask_tx.sv
// ---------------------------------------------------------------------------
// msk_ct_unmask_tx
// Output end of the masked core interface. On a rising edge of done_i the
// masked ciphertext is captured with its shares kept apart; afterwards one
// W-bit word at a time is recombined from the registered shares and streamed
// out over a valid/ready handshake, most significant word first. The share
// register is wiped once the last word has been accepted.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   done_i      core completion strobe (rising edge starts a frame)
//   msk_ct_i    128*d masked ciphertext, share j of bit o at d*o+j
//   ct_o        unmasked ciphertext word
//   ct_valid_o  ct_o holds a valid word
//   ct_ready_i  consumer accepts the word
//   ct_last_o   current word is the final word of the frame
//   busy_o      block is not idle
//   overrun_o   sticky: a done edge arrived while busy (data dropped)
// ---------------------------------------------------------------------------
module msk_ct_unmask_tx
    import msk_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 done_i,
    input  logic [CT_BITS*d-1:0] msk_ct_i,
    output logic [W-1:0]         ct_o,
    output logic                 ct_valid_o,
    input  logic                 ct_ready_i,
    output logic                 ct_last_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam int NW = nwOf(W);
    localparam int CW = cntWidth(NW);
    localparam int SW = W * d;

    if (!wLegal(W) || (d < 2)) begin : gBadParam
        $error("msk_ct_unmask_tx: unsupported parameters d=%0d W=%0d", d, W);
    end

    state_e                 state_q;
    logic [CT_BITS*d-1:0]   shareReg_q;
    logic [CW-1:0]          cnt_q;
    logic                   doneDly_q;
    logic [W-1:0]           ct_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   busy_q;
    logic                   overrun_q;

    logic                   doneRise;
    logic                   transfer;
    logic                   isLast;
    logic [CW-1:0]          wordSel;
    logic                   nextIsLast;
    logic [SW-1:0]          shareSlice;
    logic [W-1:0]           xorWord;

    assign doneRise = done_i & ~doneDly_q;
    assign transfer = valid_q & ct_ready_i;
    assign isLast   = (cnt_q == CW'(NW - 1));

    // Word whose shares feed the XOR tree: word 0 while unmasking, the word
    // after the one on the bus while sending (used on a non-final transfer).
    always_comb begin
        wordSel = '0;
        if (state_q == SEND) begin
            wordSel = cnt_q + 1'b1;
        end
    end

    assign nextIsLast = (wordSel == CW'(NW - 1));

    // Word k occupies ciphertext bits [127-k*W -: W]; its shares are the
    // contiguous slice starting at d*(128-(k+1)*W) of the share register.
    always_comb begin
        shareSlice = shareReg_q[SW*(NW-1-int'(wordSel)) +: SW];
    end

    msk_share_xor #(
        .d (d),
        .W (W)
    ) uShareXor (
        .shares_i (shareSlice),
        .word_o   (xorWord)
    );

    // Control FSM; every output is taken straight from a register so ct_o
    // never depends combinationally on msk_ct_i.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shareReg_q <= '0;
            cnt_q      <= '0;
            doneDly_q  <= 1'b0;
            ct_q       <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            doneDly_q <= done_i;
            case (state_q)
                IDLE: begin
                    if (doneRise) begin
                        shareReg_q <= msk_ct_i;
                        state_q    <= UNMASK;
                        busy_q     <= 1'b1;
                    end
                end
                UNMASK: begin
                    if (doneRise) begin
                        overrun_q <= 1'b1;
                    end
                    ct_q    <= xorWord;
                    valid_q <= 1'b1;
                    last_q  <= nextIsLast;
                    cnt_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    // A done edge here is dropped, even on the final accept.
                    if (doneRise) begin
                        overrun_q <= 1'b1;
                    end
                    if (transfer) begin
                        if (isLast) begin
                            ct_q       <= '0;
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
                            shareReg_q <= '0;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            ct_q   <= xorWord;
                            last_q <= nextIsLast;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ct_o       = ct_q;
    assign ct_valid_o = valid_q;
    assign ct_last_o  = last_q;
    assign busy_o     = busy_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_msk_ct_unmask_tx.sv
// ---------------------------------------------------------------------------
// tb_msk_ct_unmask_tx
// Scoreboard bench for msk_ct_unmask_tx. Instance A uses d=2, W=32 (four
// words per frame), instance B uses d=3, W=128 (one word). Stimulus pushes
// the expected words into a queue per instance; a monitor per instance pops
// and compares on every accepted word and checks that a stalled word holds.
// ---------------------------------------------------------------------------
module tb_msk_ct_unmask_tx;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    localparam logic [127:0] V  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] M  = {16{8'h55}};
    localparam logic [127:0] V3 = 128'ha42757d2ace7ce858ba9b1a3215a899d;

    logic          clk;
    logic          reset;

    logic          aDone;
    logic [255:0]  aMsk;
    logic [31:0]   aCt;
    logic          aValid;
    logic          aReady;
    logic          aLast;
    logic          aBusy;
    logic          aOvr;

    logic          bDone;
    logic [383:0]  bMsk;
    logic [127:0]  bCt;
    logic          bValid;
    logic          bReady;
    logic          bLast;
    logic          bBusy;
    logic          bOvr;

    exp_t          expA[$];
    exp_t          expB[$];

    int            nChecks;
    int            nPass;

    logic          aHeld;
    logic [31:0]   aHeldCt;
    logic          aHeldLast;

    msk_ct_unmask_tx #(.d(2), .W(32)) dutA (
        .clk        (clk),
        .reset      (reset),
        .done_i     (aDone),
        .msk_ct_i   (aMsk),
        .ct_o       (aCt),
        .ct_valid_o (aValid),
        .ct_ready_i (aReady),
        .ct_last_o  (aLast),
        .busy_o     (aBusy),
        .overrun_o  (aOvr)
    );

    msk_ct_unmask_tx #(.d(3), .W(128)) dutB (
        .clk        (clk),
        .reset      (reset),
        .done_i     (bDone),
        .msk_ct_i   (bMsk),
        .ct_o       (bCt),
        .ct_valid_o (bValid),
        .ct_ready_i (bReady),
        .ct_last_o  (bLast),
        .busy_o     (bBusy),
        .overrun_o  (bOvr)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Interleave two share vectors onto the d=2 bus.
    function automatic logic [255:0] build2(input logic [127:0] s0, input logic [127:0] s1);
        logic [255:0] r;
        for (int o = 0; o < 128; o++) begin
            r[2*o]   = s0[o];
            r[2*o+1] = s1[o];
        end
        return r;
    endfunction

    // Interleave three share vectors onto the d=3 bus.
    function automatic logic [383:0] build3(input logic [127:0] s0, input logic [127:0] s1,
                                            input logic [127:0] s2);
        logic [383:0] r;
        for (int o = 0; o < 128; o++) begin
            r[3*o]   = s0[o];
            r[3*o+1] = s1[o];
            r[3*o+2] = s2[o];
        end
        return r;
    endfunction

    // Queue the first n words of a 32-bit-word frame, MS word first.
    task automatic pushFrameA(input logic [127:0] ct, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data = (ct >> (96 - 32*k)) & 128'hffffffff;
            e.last = (k == 3);
            expA.push_back(e);
        end
    endtask

    // Present masked data to instance A and hold done high for some cycles.
    task automatic applyStimulus(input logic [255:0] msk, input int holdCycles);
        aMsk  = msk;
        aDone = 1'b1;
        repeat (holdCycles) begin
            @(posedge clk);
            #1;
        end
        aDone = 1'b0;
    endtask

    task automatic waitDrainA(input string name, input int budget);
        int n;
        n = 0;
        while ((expA.size() != 0 || aBusy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 128'(n < budget), 128'd1);
    endtask

    // Monitor for instance A: scoreboard pops on accepted words and checks
    // that a word offered without ready stays put until it is taken.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            aHeld = 1'b0;
        end else begin
            if (aHeld && aValid) begin
                checkOutput("holdA.ct", 128'(aCt), 128'(aHeldCt));
                checkOutput("holdA.last", 128'(aLast), 128'(aHeldLast));
            end
            if (aValid && aReady) begin
                if (expA.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpectedA: got word %h required no transfer", aCt);
                end else begin
                    e = expA.pop_front();
                    checkOutput("wordA", 128'(aCt), e.data);
                    checkOutput("lastA", 128'(aLast), 128'(e.last));
                end
            end
            aHeld     = aValid && !aReady;
            aHeldCt   = aCt;
            aHeldLast = aLast;
        end
    end

    // Monitor for instance B: single-word frames.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bValid && bReady) begin
            if (expB.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpectedB: got word %h required no transfer", bCt);
            end else begin
                e = expB.pop_front();
                checkOutput("wordB", bCt, e.data);
                checkOutput("lastB", 128'(bLast), 128'(e.last));
            end
        end
    end

    initial begin
        logic [255:0] mskV;
        logic [127:0] r1;
        logic [127:0] r2;
        exp_t         e;
        int           n;
        logic [7:0]   pattern;

        nChecks = 0;
        nPass   = 0;
        aHeld   = 1'b0;
        reset   = 1'b1;
        aDone   = 1'b0;
        aMsk    = '0;
        aReady  = 1'b0;
        bDone   = 1'b0;
        bMsk    = '0;
        bReady  = 1'b1;
        mskV    = build2(V ^ M, M);

        // Reset values on both instances.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.ct", 128'(aCt), 128'd0);
        checkOutput("rst.valid", 128'(aValid), 128'd0);
        checkOutput("rst.last", 128'(aLast), 128'd0);
        checkOutput("rst.busy", 128'(aBusy), 128'd0);
        checkOutput("rst.ovr", 128'(aOvr), 128'd0);
        checkOutput("rst.shareReg", 128'(|dutA.shareReg_q), 128'd0);
        checkOutput("rstB.valid", 128'(bValid), 128'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single frame, ready tied high, with the two-cycle latency checked.
        $display("[TB] single frame");
        aReady = 1'b1;
        pushFrameA(V, 4);
        aMsk  = mskV;
        aDone = 1'b1;
        @(posedge clk);
        #1;
        aDone = 1'b0;
        checkOutput("lat.validEarly", 128'(aValid), 128'd0);
        checkOutput("lat.busy", 128'(aBusy), 128'd1);
        @(posedge clk);
        #1;
        checkOutput("lat.valid", 128'(aValid), 128'd1);
        checkOutput("lat.word0", 128'(aCt), 128'h01234567);
        waitDrainA("drain1", 20);
        checkOutput("end1.busy", 128'(aBusy), 128'd0);
        checkOutput("end1.valid", 128'(aValid), 128'd0);

        // Backpressure with a repeating ready pattern 0,0,1,0,1,1,0,1.
        $display("[TB] backpressure");
        pattern = 8'b1011_0100;
        aReady  = 1'b0;
        pushFrameA(V, 4);
        applyStimulus(mskV, 1);
        n = 0;
        while ((expA.size() != 0 || aBusy) && n < 60) begin
            aReady = pattern[n % 8];
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain2", 128'(n < 60), 128'd1);
        checkOutput("bp.shareReg", 128'(|dutA.shareReg_q), 128'd0);
        checkOutput("bp.busy", 128'(aBusy), 128'd0);

        // done held for three cycles captures exactly one frame.
        $display("[TB] held done");
        aReady = 1'b1;
        pushFrameA(V, 4);
        applyStimulus(mskV, 3);
        waitDrainA("drain3", 20);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("held.ovr", 128'(aOvr), 128'd0);
        checkOutput("held.busy", 128'(aBusy), 128'd0);

        // Second done while sending: overrun sticks, original frame continues.
        $display("[TB] overrun");
        aReady = 1'b0;
        pushFrameA(V, 4);
        applyStimulus(mskV, 1);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(build2(~V, 128'h0), 1);
        checkOutput("ovr.set", 128'(aOvr), 128'd1);
        aReady = 1'b1;
        waitDrainA("drain4", 20);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ovr.sticky", 128'(aOvr), 128'd1);

        // Reset after the second transfer of a frame.
        $display("[TB] reset mid-frame");
        aReady = 1'b0;
        pushFrameA(V, 2);
        applyStimulus(mskV, 1);
        n = 0;
        while (!aValid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rstmid.valid", 128'(aValid), 128'd1);
        aReady = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        aReady = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rstmid.validOff", 128'(aValid), 128'd0);
        checkOutput("rstmid.busy", 128'(aBusy), 128'd0);
        checkOutput("rstmid.ovr", 128'(aOvr), 128'd0);
        aReady = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rstmid.pending", 128'(expA.size()), 128'd0);
        checkOutput("rstmid.idle", 128'(aBusy), 128'd0);
        pushFrameA(~V, 4);
        applyStimulus(build2(~V ^ M, M), 1);
        waitDrainA("drain5", 20);

        // Trivial masking: second share zero, output equals first share.
        $display("[TB] trivial mask");
        pushFrameA(128'hdeadbeef_00ff00ff_13579bdf_2468ace0, 4);
        applyStimulus(build2(128'hdeadbeef_00ff00ff_13579bdf_2468ace0, 128'h0), 1);
        waitDrainA("drain6", 20);

        // Three shares, single 128-bit word on instance B.
        $display("[TB] d=3 W=128");
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        e.data = V3;
        e.last = 1'b1;
        expB.push_back(e);
        bMsk  = build3(V3 ^ r1 ^ r2, r1, r2);
        bDone = 1'b1;
        @(posedge clk);
        #1;
        bDone = 1'b0;
        n = 0;
        while ((expB.size() != 0 || bBusy) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainB", 128'(n < 20), 128'd1);
        checkOutput("endB.busy", 128'(bBusy), 128'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/msk_ct_unmask_tx.md
Name: msk_ct_unmask_tx

Overview:
- Output end of the masked SKINNY core interface.
- On the core's done pulse, the block captures the d-share masked ciphertext bus and keeps the shares separate in a register.
- It then recombines the shares one word at a time and streams the 128-bit ciphertext out over a valid/ready handshake.
- Shares are only recombined after the register stage. The share register is cleared once the block has delivered the last word.

Parameters:
- d, 2, number of shares per bit (d >= 2)
- W, 32, output word width in bits; one of 8, 16, 32, 64, 128
- NW, 128/W, number of output words (derived, localparam)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- done_i  input  1  core completion strobe
- msk_ct_i  input  128*d  masked ciphertext; share j of bit o sits at index d*o+j
- ct_o  output  W  unmasked ciphertext word
- ct_valid_o  output  1  ct_o holds a valid word
- ct_ready_i  input  1  consumer accepts the word
- ct_last_o  output  1  current word is word NW-1
- busy_o  output  1  block is not IDLE
- overrun_o  output  1  sticky flag: a done_i edge arrived while busy

Behaviour:
- All logic is clocked on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: ct_o=0, ct_valid_o=0, ct_last_o=0, busy_o=0, overrun_o=0. Share register=0, word counter=0, done_d=0, state=IDLE.
- Done detection: done_rise = done_i & ~done_d. done_d is registered every cycle.
- FSM states: IDLE, UNMASK, SEND.
- IDLE: on done_rise, capture msk_ct_i into the share register and go to UNMASK. Otherwise stay in IDLE.
- UNMASK (one cycle):
  - ct_o <= XOR over the d shares of word 0.
  - ct_valid_o <= 1; ct_last_o <= (NW==1); counter <= 0; go to SEND.
- SEND: ct_o, ct_valid_o and ct_last_o hold stable while ct_valid_o=1 and ct_ready_i=0.
- SEND transfer: a transfer happens on any edge where ct_valid_o=1 and ct_ready_i=1.
  - Not the last word: counter increments, ct_o loads the next word's XOR in the same edge, and ct_valid_o stays 1 (back-to-back transfers allowed).
  - Last word: ct_valid_o <= 0, ct_last_o <= 0, ct_o <= 0, share register <= 0, state <= IDLE.
- Word order: word k = CT[127-k*W -: W]. Word 0 is the most significant word.
- Latency: done_rise in cycle N gives ct_valid_o=1 in cycle N+2.
- busy_o = (state != IDLE), driven from a register.
- Overrun: a done_rise in UNMASK or SEND sets overrun_o=1, and the new data is dropped. overrun_o clears only on reset.
- done_i held high for several cycles causes exactly one capture.
- A done_rise in the same edge the last word is accepted counts as overrun; the capture does not happen.
- Reset mid-operation returns the block to its reset values in the next cycle, and no further word is emitted.
- ct_o is never a combinational function of msk_ct_i.

Decomposition:
- Shared package msk_pkg:
  - state enum (IDLE, UNMASK, SEND)
  - share-index function idx(o,j)=d*o+j
  - NW derivation and the legal-W check
- Sub-module msk_share_xor #(d,W): purely combinational recombination of a W*d-bit share slice into W bits. The parent registers its output.

Test Plan:
- Single frame, d=2, W=32, ready tied to 1:
  - Stimulus: share0=V^M, share1=M, with V=128'h0123456789abcdeffedcba9876543210 and M=128'h5555...55; pulse done_i.
  - Required: ct_o = 01234567, 89abcdef, fedcba98, 76543210 in consecutive cycles, valid first seen 2 cycles after done, ct_last_o only on the 4th word, busy_o drops after the 4th word.
- Backpressure:
  - Stimulus: same frame, ct_ready_i toggling 0,0,1,0,1,1,0,1.
  - Required: each word held stable while ready=0; exactly 4 transfers in order; share register reads 0 afterwards.
- Held done and overrun:
  - Stimulus: done_i held high for 3 cycles.
  - Required: exactly one frame emitted, overrun_o=0.
  - Stimulus: a second done pulse during SEND.
  - Required: overrun_o=1 and sticky; the frame continues with the original data.
- Reset mid-frame:
  - Stimulus: assert reset after the 2nd transfer.
  - Required: next cycle ct_valid_o=0, busy_o=0, overrun_o=0; no further words; a new done works normally.
- Masking sanity, d=3, W=128:
  - Stimulus: V=128'ha42757d2ace7ce858ba9b1a3215a899d spread across 3 random shares.
  - Required: single word equals V with ct_last_o=1.
- Trivial masking, d=2:
  - Stimulus: share1=0 (constant masking).
  - Required: output equals share0.
